// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, deframes LSB-first characters, pulses rx_valid/frame_err for one cycle.
// No backpressure on the byte output. Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;
  logic                   rxd_s;
`ifdef UART_RX_PARITY_EN
  logic                   pbad_q, pbad_d;
  logic                   perr_q, perr_d;
`endif

  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rxd};
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d    = pbad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        // Mid-start check: a line that is high again was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          pbad_d  = (^shift_q) ^ rxd_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid-stop lets a start bit with zero idle gap be caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (pbad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync_q    <= '1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= pbad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed plus random frames, expected strobes queued per frame and matched by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // Start edge on rxd to strobe: synchroniser, half bit, data/parity/stop bits, output register.
  localparam int LAT = SYNC + CPB / 2 + (9 + NPAR) * CPB + 1;

  typedef struct {
    int         kind;   // 0 = rx_valid, 1 = frame_err, 2 = parity_err
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   kind_now;
    forever begin
      @(negedge clk);
      if (!rst && (rx_valid || frame_err || parity_err)) begin
        chk("single_strobe", 32'($countones({rx_valid, frame_err, parity_err})), 32'd1);
        kind_now = rx_valid ? 0 : (frame_err ? 1 : 2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got kind %0d data 0x%0h, expected none (cycle %0d)",
                   kind_now, rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(kind_now), 32'(e.kind));
          chk("rx_data", 32'(rx_data), 32'(e.data));
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic drive_bits(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: stop low -> frame error; bad even parity -> parity error; else byte delivered.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.data = last_good;
    if (!stop) begin
      e.kind = 1;
    end else if (NPAR == 1 && ((^d) ^ pbit)) begin
      e.kind = 2;
    end else begin
      e.kind    = 0;
      e.data    = d;
      last_good = d;
    end
    exp_q.push_back(e);
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(d[i], CPB);
    if (NPAR == 1) drive_bits(pbit, CPB);
    drive_bits(stop, CPB);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       pbit;
    int         gap;
    logic [7:0] c7;

    rst       = 1'b1;
    rxd       = 1'b1;
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    fork monitor(); join_none

    drive_bits(1'b1, 2 * CPB);
    send_frame(8'h55, 1'b1, ^8'h55);
    chk("busy_after_55", 32'(busy), 32'd0);
    drive_bits(1'b1, CPB);

    send_frame(8'hA3, 1'b1, ^8'hA3);
    send_frame(8'h00, 1'b1, 1'b0);
    drive_bits(1'b1, CPB);

    drive_bits(1'b0, 5);
    drive_bits(1'b1, 2 * CPB);
    chk("busy_after_glitch", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    drive_bits(1'b1, CPB);

    send_frame(8'hFF, 1'b0, 1'b0);
    drive_bits(1'b0, 400);
    chk("busy_in_break", 32'(busy), 32'd1);
    drive_bits(1'b1, 2 * CPB);
    chk("busy_after_break", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b1, ^8'h81);
    drive_bits(1'b1, CPB);

    // C7 aborted by reset during data bit 4: no strobe expected for it.
    c7 = 8'hC7;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bits(c7[i], CPB);
    drive_bits(c7[4], CPB / 2);
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    last_good = 8'h00;
    chk("midframe_reset_rx_data", 32'(rx_data), 32'h00);
    chk("midframe_reset_busy", 32'(busy), 32'd0);
    drive_bits(1'b1, 2 * CPB);
    send_frame(8'h12, 1'b1, ^8'h12);
    drive_bits(1'b1, CPB);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bits(1'b1, CPB);
    send_frame(8'h07, 1'b1, 1'b0);
    drive_bits(1'b1, CPB);
`endif

    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      gap  = stop ? $urandom_range(0, 20) : $urandom_range(CPB, 2 * CPB);
      send_frame(d, stop, pbit);
      if (gap > 0) drive_bits(1'b1, gap);
    end

    drive_bits(1'b1, 2 * CPB);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
